squarer_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 3-bit squarer (Y = A×A, 6-bit result) among NREQ requesters. Each requester raises a level request with a 3-bit operand. The block grants one requester at a time, latches its operand, registers the squared result and returns it with a one-cycle done pulse. It sits between the requesting control blocks and the single squarer instance, so there is one squarer per design instead of one per client.

---
 rtl/squarer_arbiter.sv | 87 ++++++++
 tb/tb_squarer_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/squarer_arbiter.sv
// squarer_arbiter: round-robin arbiter sharing one 3-bit squarer among NREQ requesters
module squarer_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_i,
  input  logic [3*NREQ-1:0]   a_i,
  output logic [NREQ-1:0]     grant_o,
  output logic [NREQ-1:0]     done_o,
  output logic [5:0]          y_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    ops_cnt_o
);
  localparam int IW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, COMPUTE = 2'd1, RESP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, sel;
  logic [NREQ-1:0] grant_q, grant_d, gsel;
  logic [2:0] op_q, op_d, op_sel;
  logic [5:0] y_q, y_d, sq;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  int best;
  assign sq = {3'b000, op_q} * {3'b000, op_q};
  always_comb begin
    best = NREQ;
    sel = '0;
    gsel = '0;
    op_sel = '0;
    for (int k = 0; k < NREQ; k++)
      if (req_i[k] && (k - int'(ptr_q) + NREQ) % NREQ < best) begin
        best = (k - int'(ptr_q) + NREQ) % NREQ;
        sel = IW'(k);
        gsel = '0;
        gsel[k] = 1'b1;
        op_sel = a_i[3*k +: 3];
      end
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    grant_d = grant_q;
    op_d = op_q;
    y_d = y_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && best < NREQ) begin
      state_d = COMPUTE;
      idx_d = sel;
      grant_d = gsel;
      op_d = op_sel;
    end
    if (state_q == COMPUTE) begin
      state_d = RESP;
      y_d = sq;
    end
    if (state_q == RESP) begin
      state_d = IDLE;
      grant_d = '0;
      cnt_d = cnt_q + CNT_W'(1);
      ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      grant_q <= '0;
      op_q <= '0;
      y_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      grant_q <= grant_d;
      op_q <= op_d;
      y_q <= y_d;
      cnt_q <= cnt_d;
    end
  end
  assign grant_o = grant_q;
  assign done_o = (state_q == RESP) ? grant_q : '0;
  assign y_o = y_q;
  assign busy_o = state_q != IDLE;
  assign ops_cnt_o = cnt_q;
endmodule

// File: tb/tb_squarer_arbiter.sv
// tb_squarer_arbiter: scoreboard bench with transaction-level round-robin model
module tb_squarer_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [3*N-1:0] a = '0;
  logic [N-1:0] grant_o, done_o, grant2, done2;
  logic [5:0] y_o, y2;
  logic busy_o, busy2;
  logic [7:0] cnt_o;
  logic [1:0] cnt2;
  int tests = 0, fails = 0;
  int cd = 0, ptr = 0, gidx = 0, mcnt = 0, ym = 0, py = 0;
  bit started = 0;
  int exp_idx[$], exp_y[$], srv_idx[$], srv_y[$];
  squarer_arbiter #(.NREQ(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_i(req), .a_i(a),
    .grant_o(grant_o), .done_o(done_o), .y_o(y_o), .busy_o(busy_o), .ops_cnt_o(cnt_o)
  );
  squarer_arbiter #(.NREQ(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_i(req), .a_i(a),
    .grant_o(grant2), .done_o(done2), .y_o(y2), .busy_o(busy2), .ops_cnt_o(cnt2)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    int v;
    #1;
    if (rst) begin
      exp_idx.delete();
      exp_y.delete();
      cd = 0;
      ptr = 0;
      mcnt = 0;
      ym = 0;
    end else if (cd == 0) begin
      if (req != 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(ptr + k) % N]) gidx = (ptr + k) % N;
        v = int'((a >> (3 * gidx)) & 12'd7);
        py = v * v;
        exp_idx.push_back(gidx);
        exp_y.push_back(py);
        cd = 2;
      end
    end else begin
      if (cd == 2) ym = py;
      if (cd == 1) begin
        mcnt++;
        ptr = (gidx + 1) % N;
      end
      cd--;
    end
    @(posedge clk);
    @(negedge clk);
    req = req & ~done_o;
  endtask
  task automatic drain(int bound);
    int n = 0;
    while (req != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", int'(req), 0);
    tick();
  endtask
  always @(negedge clk) if (started) begin
    chk("grant", int'(grant_o), cd != 0 ? (1 << gidx) : 0);
    chk("done", int'(done_o), cd == 1 ? (1 << gidx) : 0);
    chk("busy", int'(busy_o), int'(cd != 0));
    chk("y", int'(y_o), ym);
    chk("cnt", int'(cnt_o), mcnt % 256);
    chk("cnt_w2", int'(cnt2), mcnt % 4);
    chk("grant_onehot", int'($onehot0(grant_o)), 1);
    if (done_o != 0) begin
      if (exp_idx.size() == 0) chk("unexpected_done", int'(done_o), 0);
      else begin
        int ei, ey;
        ei = exp_idx.pop_front();
        ey = exp_y.pop_front();
        chk("sb_done", int'(done_o), 1 << ei);
        chk("sb_y", int'(y_o), ey);
        srv_idx.push_back(ei);
        srv_y.push_back(int'(y_o));
      end
    end
  end
  initial begin
    int n, base;
    tick();
    started = 1;
    tick();
    chk("rst_grant", int'(grant_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_y", int'(y_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_cnt", int'(cnt_o), 0);
    rst = 1'b0;
    for (int v = 0; v < 8; v++) begin
      a[2:0] = 3'(v);
      req[0] = 1'b1;
      n = 0;
      while (req[0] && n < 10) begin
        tick();
        n++;
      end
      chk("latency", n, 2);
      tick();
      chk("exh_y", srv_y.size() > 0 ? srv_y[srv_y.size() - 1] : -1, v * v);
    end
    chk("cnt_after8", int'(cnt_o), 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = srv_idx.size();
    a = {3'd4, 3'd3, 3'd2, 3'd1};
    req = 4'hF;
    drain(40);
    chk("sim_count", srv_idx.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk("sim_order", base + i < srv_idx.size() ? srv_idx[base + i] : -1, i);
      chk("sim_y", base + i < srv_y.size() ? srv_y[base + i] : -1, (i + 1) * (i + 1));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a = 12'($urandom);
    req = 4'b0010;
    drain(10);
    base = srv_idx.size();
    req = 4'b0011;
    drain(20);
    chk("rr_first", base < srv_idx.size() ? srv_idx[base] : -1, 0);
    chk("rr_second", base + 1 < srv_idx.size() ? srv_idx[base + 1] : -1, 1);
    a[8:6] = 3'd6;
    req = 4'b0100;
    tick();
    a[8:6] = 3'd3;
    drain(10);
    chk("opchg_idx", srv_idx.size() > 0 ? srv_idx[srv_idx.size() - 1] : -1, 2);
    chk("opchg_y", srv_y.size() > 0 ? srv_y[srv_y.size() - 1] : -1, 36);
    base = srv_idx.size();
    a[2:0] = 3'd5;
    req = 4'b0001;
    tick();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    chk("abort_grant", int'(grant_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_y", int'(y_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_cnt", int'(cnt_o), 0);
    tick();
    tick();
    chk("abort_no_done", srv_idx.size(), base);
    a[11:9] = 3'd5;
    req = 4'b1000;
    drain(10);
    chk("post_abort_idx", srv_idx.size() > 0 ? srv_idx[srv_idx.size() - 1] : -1, 3);
    chk("post_abort_y", srv_y.size() > 0 ? srv_y[srv_y.size() - 1] : -1, 25);
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      a = 12'($urandom);
      tick();
    end
    drain(200);
    tick();
    chk("sb_empty", exp_idx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
